// File: rtl/parity_frame_checker.sv
// Serial parity frame receiver: assembles DATA_W data bits (MSB first) plus a trailing
// parity bit, checks odd/even parity and keeps saturating error / wrapping frame counters.
module parity_frame_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bitIn,
    input  logic              bitValid,
    input  logic              sof,
    input  logic              oddMode,
    input  logic              clrCnt,
    output logic [DATA_W-1:0] dataOut,
    output logic              parityOut,
    output logic              frameValid,
    output logic              isErr,
    output logic [CNT_W-1:0]  errCnt,
    output logic [CNT_W-1:0]  frameCnt,
    output logic              busy
);

    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              start, shift, accept, trunc;
    logic              frame_p, err_nxt, err_inc;

    // Handshake: a bit is consumed on any rising edge where bitValid=1; there is no
    // backpressure, so the upstream stage may present bits with arbitrary gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        shift     = 1'b0;
        accept    = 1'b0;
        trunc     = 1'b0;
        case (state)
            IDLE: begin
                if (bitValid && sof) begin
                    start     = 1'b1;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (bitValid) begin
                    if (sof) begin
                        // Truncated frame: restart with this bit as the new MSB.
                        trunc = 1'b1;
                        start = 1'b1;
                    end else if (bit_cnt == BW'(DATA_W)) begin
                        accept    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state == RECV);
    assign frame_p = (^shreg) ^ bitIn;
    assign err_nxt = oddMode ? ~frame_p : frame_p;
    assign err_inc = trunc | (accept & err_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            dataOut    <= '0;
            parityOut  <= 1'b0;
            isErr      <= 1'b0;
            frameValid <= 1'b0;
        end else begin
            frameValid <= accept;
            if (start) begin
                shreg   <= DATA_W'(bitIn);
                bit_cnt <= BW'(1);
            end else if (shift) begin
                shreg   <= (shreg << 1) | DATA_W'(bitIn);
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (accept) begin
                dataOut   <= shreg;
                parityOut <= bitIn;
                isErr     <= err_nxt;
                bit_cnt   <= '0;
            end
        end
    end

    // Clear wins over any increment landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCnt   <= '0;
            frameCnt <= '0;
        end else if (clrCnt) begin
            errCnt   <= '0;
            frameCnt <= '0;
        end else begin
            if (accept)                   frameCnt <= frameCnt + CNT_W'(1);
            if (err_inc && errCnt != '1)  errCnt   <= errCnt + CNT_W'(1);
        end
    end

endmodule
